kws_feat_window: RTL

//  Downstream of CMVN. Collects normalised features (Q1.7.24, addr 0..NUM_FEAT-1) into frames.

---
 rtl/kws_feat_window_if.sv | 28 ++
 rtl/kws_feat_window.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/kws_feat_window_if.sv
// Feature-in / window-out bundle between CMVN, the window framer and the KWS network input.
// The framer is the slave: it sinks in_* and drives out_* plus the error pulses.
interface kws_feat_window_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic [ADDR_W-1:0] in_addr;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_feat;
   logic [2:0]        out_frame;
   logic              out_last;
   logic              frame_err;
   logic              overrun;

   modport master (
      output in_valid, in_data, in_addr, out_ready,
      input  out_valid, out_data, out_feat, out_frame, out_last, frame_err, overrun
   );

   modport slave (
      input  in_valid, in_data, in_addr, out_ready,
      output out_valid, out_data, out_feat, out_frame, out_last, frame_err, overrun
   );
endinterface

// File: rtl/kws_feat_window.sv
// Sliding-window framer: ring of CONTEXT+1 frame slots, streams the CONTEXT newest frames oldest first.
// First word registered one cycle after frame completion; words advance only on out_valid && out_ready.
module kws_feat_window #(
   parameter int NUM_FEAT = 20,
   parameter int CONTEXT  = 8,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   kws_feat_window_if.slave fw
);
   localparam int SLOTS   = CONTEXT + 1;
   localparam int SLOT_W  = $clog2(SLOTS);
   localparam int FS_W    = $clog2(CONTEXT + 1);
   localparam int FRAME_W = 3;

   localparam logic [ADDR_W-1:0]  LAST_FEAT  = ADDR_W'(NUM_FEAT - 1);
   localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(CONTEXT - 1);
   localparam logic [FS_W-1:0]    FS_FULL    = FS_W'(CONTEXT);
   localparam logic [FS_W-1:0]    FS_PRE     = FS_W'(CONTEXT - 1);
   localparam logic [SLOT_W-1:0]  SLOT_MAX   = SLOT_W'(SLOTS - 1);

   typedef logic [SLOT_W-1:0] slot_t;
   typedef enum logic {IDLE, EMIT} state_t;

   function automatic slot_t slot_inc(input slot_t s);
      return (s == SLOT_MAX) ? '0 : s + slot_t'(1);
   endfunction

   function automatic slot_t slot_of(input slot_t base, input logic [FRAME_W-1:0] f);
      logic [SLOT_W:0] sum;
      sum = {1'b0, base} + (SLOT_W+1)'(f);
      if (sum >= (SLOT_W+1)'(SLOTS))
         sum = sum - (SLOT_W+1)'(SLOTS);
      return sum[SLOT_W-1:0];
   endfunction

   logic [DATA_W-1:0] ram [SLOTS][NUM_FEAT];

   // assembler state
   logic [ADDR_W-1:0] exp_addr;
   slot_t             wr_slot;
   logic [FS_W-1:0]   frames_stored;
   logic              dropping;

   logic  start, seq_ok, addr_err, accept, ovr_cond, keep, last_word, complete, win_rdy;
   slot_t win_base;

   // output FSM state
   state_t state, state_n;
   slot_t  emit_base, emit_base_n, pend_base, pend_base_n, go_base, rd_slot;
   logic   pending, pending_n, valid_n, load, go, fire;
   logic [FRAME_W-1:0] frame_n;
   logic [ADDR_W-1:0]  feat_n;

   always_comb begin
      start     = fw.in_valid && (fw.in_addr == '0);
      seq_ok    = fw.in_valid && (fw.in_addr == exp_addr);
      addr_err  = fw.in_valid && !seq_ok;
      accept    = seq_ok || start;
      // A new frame would land in the slot currently being streamed.
      ovr_cond  = (state == EMIT) && (wr_slot == emit_base);
      keep      = start ? !ovr_cond : !dropping;
      last_word = accept && (fw.in_addr == LAST_FEAT);
      complete  = last_word && keep;
      win_rdy   = complete && (frames_stored >= FS_PRE);
      win_base  = slot_inc(slot_inc(wr_slot));
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         exp_addr      <= '0;
         wr_slot       <= '0;
         frames_stored <= '0;
         dropping      <= 1'b0;
         fw.frame_err  <= 1'b0;
         fw.overrun    <= 1'b0;
      end else begin
         fw.frame_err <= addr_err;
         fw.overrun   <= start && ovr_cond;

         if (accept)
            exp_addr <= last_word ? '0 : fw.in_addr + ADDR_W'(1);
         else if (addr_err)
            exp_addr <= '0;

         if (last_word || (addr_err && !start))
            dropping <= 1'b0;
         else if (start)
            dropping <= ovr_cond;

         if (complete) begin
            wr_slot <= slot_inc(wr_slot);
            if (frames_stored != FS_FULL)
               frames_stored <= frames_stored + FS_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!(rst || flush) && accept && keep)
         ram[wr_slot][fw.in_addr] <= fw.in_data;
   end

   always_comb begin
      state_n     = state;
      emit_base_n = emit_base;
      pending_n   = pending;
      pend_base_n = pend_base;
      valid_n     = fw.out_valid;
      frame_n     = fw.out_frame;
      feat_n      = fw.out_feat;
      load        = 1'b0;
      go          = 1'b0;
      go_base     = win_base;
      fire        = fw.out_valid && fw.out_ready;

      unique case (state)
         IDLE: begin
            if (pending) begin
               go          = 1'b1;
               go_base     = pend_base;
               pending_n   = win_rdy;
               pend_base_n = win_base;
            end else if (win_rdy) begin
               go = 1'b1;
            end
         end
         EMIT: begin
            if (win_rdy) begin
               pending_n   = 1'b1;
               pend_base_n = win_base;
            end
            if (fire) begin
               if (fw.out_last) begin
                  // Back-to-back windows: restart without a bubble.
                  if (pending) begin
                     go        = 1'b1;
                     go_base   = pend_base;
                     pending_n = win_rdy;
                  end else if (win_rdy) begin
                     go        = 1'b1;
                     pending_n = 1'b0;
                  end else begin
                     state_n = IDLE;
                     valid_n = 1'b0;
                  end
               end else begin
                  load = 1'b1;
                  if (fw.out_feat == LAST_FEAT) begin
                     feat_n  = '0;
                     frame_n = fw.out_frame + FRAME_W'(1);
                  end else begin
                     feat_n = fw.out_feat + ADDR_W'(1);
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase

      if (go) begin
         state_n     = EMIT;
         emit_base_n = go_base;
         valid_n     = 1'b1;
         load        = 1'b1;
         frame_n     = '0;
         feat_n      = '0;
      end

      rd_slot = slot_of(emit_base_n, frame_n);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state        <= IDLE;
         emit_base    <= '0;
         pending      <= 1'b0;
         pend_base    <= '0;
         fw.out_valid <= 1'b0;
         fw.out_data  <= '0;
         fw.out_feat  <= '0;
         fw.out_frame <= '0;
         fw.out_last  <= 1'b0;
      end else begin
         state        <= state_n;
         emit_base    <= emit_base_n;
         pending      <= pending_n;
         pend_base    <= pend_base_n;
         fw.out_valid <= valid_n;
         fw.out_last  <= valid_n && (frame_n == LAST_FRAME) && (feat_n == LAST_FEAT);
         if (load) begin
            fw.out_data  <= ram[rd_slot][feat_n];
            fw.out_feat  <= feat_n;
            fw.out_frame <= frame_n;
         end
      end
   end
endmodule
